// File: rtl/mm_pkg.sv
// Shared types and widths for the matrix-multiply accelerator: element, product,
// accumulator and address widths plus the MAC sequencer state encoding.
package mm_pkg;

  localparam int ELEM_W = 4;
  localparam int PROD_W = 8;
  localparam int ACC_W  = 10;
  localparam int ADDR_W = 4;
  localparam int MAX_N  = 4;
  localparam int CNT_W  = $clog2(MAX_N);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    WRITE,
    DONE
  } mm_state_e;

  // Row-major element index; n <= MAX_N keeps the result inside ADDR_W bits.
  function automatic logic [ADDR_W-1:0] row_major(input logic [CNT_W-1:0] row,
                                                  input logic [CNT_W-1:0] col,
                                                  input int               n);
    return ADDR_W'(row) * ADDR_W'(n) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/matmul_mac_ctrl_if.sv
// Bundle between the MAC sequencer and its surroundings: operand/result stores,
// the accumulator and the host start/busy/done handshake.
interface matmul_mac_ctrl_if;
  import mm_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic              mac_clear;
  logic              mac_ld;
  logic [ACC_W-1:0]  acc_in;
  logic [ADDR_W-1:0] c_addr;
  logic [ACC_W-1:0]  c_data;
  logic              c_we;
  logic              busy;
  logic              done;

  modport master (
    input  start, acc_in,
    output a_addr, b_addr, mac_clear, mac_ld, c_addr, c_data, c_we, busy, done
  );

  modport slave (
    output start, acc_in,
    input  a_addr, b_addr, mac_clear, mac_ld, c_addr, c_data, c_we, busy, done
  );

endinterface

// File: rtl/mm_index_counter.sv
// Cascaded k/j/i index counters with wrap flags and row-major operand/result
// address generation for an N x N multiply.
module mm_index_counter
  import mm_pkg::*;
#(
  parameter int N = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              k_clr,
  input  logic              k_inc,
  input  logic              ij_adv,
  input  logic              all_clr,
  output logic              k_last,
  output logic              j_last,
  output logic              i_last,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic [ADDR_W-1:0] c_addr
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] k_q;
  logic [CNT_W-1:0] j_q;
  logic [CNT_W-1:0] i_q;

  assign k_last = (k_q == LAST);
  assign j_last = (j_q == LAST);
  assign i_last = (i_q == LAST);

  assign a_addr = row_major(i_q, k_q, N);
  assign b_addr = row_major(k_q, j_q, N);
  assign c_addr = row_major(i_q, j_q, N);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q <= '0;
      j_q <= '0;
      i_q <= '0;
    end else if (all_clr) begin
      k_q <= '0;
      j_q <= '0;
      i_q <= '0;
    end else begin
      if (k_clr) begin
        k_q <= '0;
      end else if (k_inc) begin
        k_q <= k_last ? '0 : k_q + 1'b1;
      end
      // j wraps into i; after the final element i stays put until all_clr
      if (ij_adv) begin
        if (!j_last) begin
          j_q <= j_q + 1'b1;
        end else begin
          j_q <= '0;
          if (!i_last) begin
            i_q <= i_q + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/matmul_mac_ctrl.sv
// Sequencer driving one shared MAC accumulator through C = A x B for N x N
// matrices: clear, N accumulate cycles, then a result write per C element.
module matmul_mac_ctrl
  import mm_pkg::*;
#(
  parameter int N = 2
) (
  input  logic              clk,
  input  logic              reset,
  matmul_mac_ctrl_if.master bus
);

  if (N < 2 || N > MAX_N) begin : g_bad_n
    $error("matmul_mac_ctrl: N=%0d outside legal range 2..%0d", N, MAX_N);
  end

  if (PROD_W != 2 * ELEM_W ||
      MAX_N * ((1 << ELEM_W) - 1) * ((1 << ELEM_W) - 1) >= (1 << ACC_W)) begin : g_bad_w
    $error("matmul_mac_ctrl: accumulator width cannot hold a full dot product");
  end

  mm_state_e state;
  logic      mac_clear_q;
  logic      mac_ld_q;
  logic      c_we_q;
  logic      busy_q;
  logic      done_q;

  logic      k_last;
  logic      j_last;
  logic      i_last;

  mm_index_counter #(
    .N(N)
  ) u_idx (
    .clk     (clk),
    .reset   (reset),
    .k_clr   (state == CLEAR),
    .k_inc   (state == ACCUM),
    .ij_adv  (state == WRITE),
    .all_clr (state == DONE),
    .k_last  (k_last),
    .j_last  (j_last),
    .i_last  (i_last),
    .a_addr  (bus.a_addr),
    .b_addr  (bus.b_addr),
    .c_addr  (bus.c_addr)
  );

  // Outputs are registered together with the next state so they track it exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mac_clear_q <= 1'b0;
      mac_ld_q    <= 1'b0;
      c_we_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mac_clear_q <= 1'b0;
      mac_ld_q    <= 1'b0;
      c_we_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= CLEAR;
            mac_clear_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
          end
        end
        CLEAR: begin
          state    <= ACCUM;
          mac_ld_q <= 1'b1;
        end
        ACCUM: begin
          if (k_last) begin
            state  <= WRITE;
            c_we_q <= 1'b1;
          end else begin
            mac_ld_q <= 1'b1;
          end
        end
        WRITE: begin
          if (j_last && i_last) begin
            state  <= DONE;
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            state       <= CLEAR;
            mac_clear_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mac_clear = mac_clear_q;
  assign bus.mac_ld    = mac_ld_q;
  assign bus.c_we      = c_we_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.c_data    = c_we_q ? bus.acc_in : '0;

endmodule

// File: tb/tb_matmul_mac_ctrl.sv
// Directed bench for matmul_mac_ctrl: N=2 and N=4 instances, bench-side operand
// stores and accumulator, hand-computed C values and cycle positions.
module tb_matmul_mac_ctrl;
  import mm_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2;
  logic rst4;
  logic start;
  logic sel;

  int n_checks = 0;
  int n_errors = 0;

  matmul_mac_ctrl_if if2 ();
  matmul_mac_ctrl_if if4 ();

  matmul_mac_ctrl #(.N(2)) dut2 (.clk(clk), .reset(rst2), .bus(if2.master));
  matmul_mac_ctrl #(.N(4)) dut4 (.clk(clk), .reset(rst4), .bus(if4.master));

  logic [ELEM_W-1:0] am2 [16];
  logic [ELEM_W-1:0] bm2 [16];
  logic [ELEM_W-1:0] am4 [16];
  logic [ELEM_W-1:0] bm4 [16];
  logic [ACC_W-1:0]  acc2;
  logic [ACC_W-1:0]  acc4;
  logic [PROD_W-1:0] p2;
  logic [PROD_W-1:0] p4;
  int                expc [16];

  assign p2 = {4'b0, am2[if2.a_addr]} * {4'b0, bm2[if2.b_addr]};
  assign p4 = {4'b0, am4[if4.a_addr]} * {4'b0, bm4[if4.b_addr]};

  always_ff @(posedge clk) begin
    if (if2.mac_clear) acc2 <= '0;
    else if (if2.mac_ld) acc2 <= acc2 + ACC_W'(p2);
    if (if4.mac_clear) acc4 <= '0;
    else if (if4.mac_ld) acc4 <= acc4 + ACC_W'(p4);
  end

  assign if2.acc_in = acc2;
  assign if4.acc_in = acc4;
  assign if2.start  = start & ~sel;
  assign if4.start  = start & sel;

  logic              o_clr, o_ld, o_we, o_busy, o_done;
  logic [ADDR_W-1:0] o_a, o_b, o_c;
  logic [ACC_W-1:0]  o_d;
  assign o_clr  = sel ? if4.mac_clear : if2.mac_clear;
  assign o_ld   = sel ? if4.mac_ld    : if2.mac_ld;
  assign o_we   = sel ? if4.c_we      : if2.c_we;
  assign o_busy = sel ? if4.busy      : if2.busy;
  assign o_done = sel ? if4.done      : if2.done;
  assign o_a    = sel ? if4.a_addr    : if2.a_addr;
  assign o_b    = sel ? if4.b_addr    : if2.b_addr;
  assign o_c    = sel ? if4.c_addr    : if2.c_addr;
  assign o_d    = sel ? if4.c_data    : if2.c_data;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_mats2(input int a0, a1, a2, a3, b0, b1, b2, b3,
                           input int c0, c1, c2, c3);
    am2[0] = 4'(a0); am2[1] = 4'(a1); am2[2] = 4'(a2); am2[3] = 4'(a3);
    bm2[0] = 4'(b0); bm2[1] = 4'(b1); bm2[2] = 4'(b2); bm2[3] = 4'(b3);
    expc[0] = c0; expc[1] = c1; expc[2] = c2; expc[3] = c3;
  endtask

  // Entered and left just after a rising edge. mode: 0 single pulse,
  // 1 extra pulses in cycles 5 and 17, 2 start held high throughout.
  task automatic run_mm(input string nm, input int nn, input int mode, input int last_cyc);
    int tot = nn * nn * (nn + 2) + 1;
    int wr_cnt = 0, done_cnt = 0, done_cyc = -1, clr2 = -1;
    int busy_bad = 0, both_bad = 0, cdat_bad = 0;
    for (int cyc = 0; cyc <= last_cyc; cyc++) begin
      start = (cyc == 0) || (mode == 1 && (cyc == 5 || cyc == 17)) || (mode == 2);
      @(negedge clk);
      if (cyc <= tot && o_busy !== (cyc >= 1 && cyc < tot)) busy_bad++;
      if (o_clr && o_ld) both_bad++;
      if (!o_we && o_d !== '0) cdat_bad++;
      if (o_we) begin
        if (wr_cnt < nn * nn) begin
          check_val($sformatf("%s_wr%0d_cyc", nm, wr_cnt), cyc, (wr_cnt + 1) * (nn + 2));
          check_val($sformatf("%s_wr%0d_addr", nm, wr_cnt), int'(o_c), wr_cnt);
          check_val($sformatf("%s_wr%0d_data", nm, wr_cnt), int'(o_d), expc[wr_cnt]);
        end
        wr_cnt++;
      end
      if (o_ld && cyc < tot) begin
        int e, k, i, j;
        e = (cyc - 1) / (nn + 2);
        k = (cyc - 1) % (nn + 2) - 1;
        i = e / nn;
        j = e % nn;
        check_val($sformatf("%s_a_addr_c%0d", nm, cyc), int'(o_a), i * nn + k);
        check_val($sformatf("%s_b_addr_c%0d", nm, cyc), int'(o_b), k * nn + j);
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (o_clr && cyc > tot && clr2 < 0) clr2 = cyc;
      @(posedge clk);
      #1;
    end
    check_val({nm, "_writes"}, wr_cnt, nn * nn);
    check_val({nm, "_done_cnt"}, done_cnt, 1);
    check_val({nm, "_done_cyc"}, done_cyc, tot);
    check_val({nm, "_busy_bad"}, busy_bad, 0);
    check_val({nm, "_clr_ld_both"}, both_bad, 0);
    check_val({nm, "_cdata_idle"}, cdat_bad, 0);
    if (mode == 2) check_val({nm, "_second_clear"}, clr2, tot + 2);
  endtask

  task automatic step_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet_bad;
    sel = 1'b0;
    start = 1'b0;
    rst2 = 1'b1;
    rst4 = 1'b1;
    for (int x = 0; x < 16; x++) begin
      am2[x] = '0; bm2[x] = '0; am4[x] = 4'd15; bm4[x] = 4'd15; expc[x] = 0;
    end
    step_cycles(2);

    check_val("rst_busy", o_busy, 0);
    check_val("rst_done", o_done, 0);
    check_val("rst_we", o_we, 0);
    check_val("rst_clr", o_clr, 0);
    check_val("rst_ld", o_ld, 0);
    check_val("rst_a_addr", int'(o_a), 0);
    check_val("rst_c_addr", int'(o_c), 0);
    rst2 = 1'b0;
    rst4 = 1'b0;
    step_cycles(1);

    set_mats2(1, 0, 0, 1, 3, 4, 5, 6, 3, 4, 5, 6);
    run_mm("ident", 2, 0, 20);

    set_mats2(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50);
    run_mm("gen2", 2, 0, 20);

    set_mats2(1, 0, 0, 1, 3, 4, 5, 6, 3, 4, 5, 6);
    run_mm("repulse", 2, 1, 20);
    run_mm("held", 2, 2, 20);
    start = 1'b0;
    rst2 = 1'b1;
    step_cycles(1);
    rst2 = 1'b0;
    step_cycles(1);

    // Asynchronous reset in the middle of element 2's accumulation
    set_mats2(1, 2, 3, 4, 5, 6, 7, 8, 19, 22, 43, 50);
    start = 1'b1;
    step_cycles(1);
    start = 1'b0;
    step_cycles(9);
    @(negedge clk);
    check_val("abort_pre_ld", o_ld, 1);
    check_val("abort_pre_a_addr", int'(o_a), 2);
    #1 rst2 = 1'b1;
    #1;
    check_val("abort_ld", o_ld, 0);
    check_val("abort_busy", o_busy, 0);
    check_val("abort_a_addr", int'(o_a), 0);
    check_val("abort_c_addr", int'(o_c), 0);
    step_cycles(2);
    rst2 = 1'b0;
    quiet_bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_we || o_busy || o_clr || o_ld) quiet_bad++;
      @(posedge clk);
      #1;
    end
    check_val("abort_quiet", quiet_bad, 0);
    run_mm("after_abort", 2, 0, 20);

    // Asynchronous reset landing in the DONE cycle
    start = 1'b1;
    step_cycles(1);
    start = 1'b0;
    step_cycles(16);
    @(negedge clk);
    check_val("dreset_pre_done", o_done, 1);
    check_val("dreset_pre_c_addr", int'(o_c), 2);
    #1 rst2 = 1'b1;
    #1;
    check_val("dreset_done", o_done, 0);
    check_val("dreset_busy", o_busy, 0);
    check_val("dreset_a_addr", int'(o_a), 0);
    check_val("dreset_b_addr", int'(o_b), 0);
    check_val("dreset_c_addr", int'(o_c), 0);
    step_cycles(1);
    rst2 = 1'b0;
    step_cycles(1);
    @(negedge clk);
    check_val("dreset_idle_busy", o_busy, 0);
    check_val("dreset_idle_clr", o_clr, 0);
    @(posedge clk);
    #1;

    sel = 1'b1;
    for (int x = 0; x < 16; x++) expc[x] = 900;
    run_mm("full4", 4, 0, 100);
    sel = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
